// File: rtl/cbx_mem_bank_loader_pkg.sv
// Shared types and sizing helpers for the connection-block configuration loader.
// Optional feature macro used by this slice: CBX_MEM_BANK_LOADER_PARITY_EN.
package cb_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    WRITE,
    HOLD
  } cb_state_e;

  localparam int unsigned WL_W_DEF = 72;
  localparam int unsigned ROW_W    = $clog2(WL_W_DEF);

  function automatic int unsigned calc_nw(input int unsigned bl_w, input int unsigned data_w);
    return (bl_w + data_w - 1) / data_w;
  endfunction

  function automatic int unsigned row_width(input int unsigned wl_w);
    return (wl_w > 1) ? $clog2(wl_w) : 1;
  endfunction

endpackage

// File: rtl/cbx_mem_bank_loader_if.sv
// Valid/ready configuration word stream into the bank loader.
// CBX_MEM_BANK_LOADER_PARITY_EN adds a per-word odd-parity bit.
interface cbx_mem_bank_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
`ifdef CBX_MEM_BANK_LOADER_PARITY_EN
  logic              cfg_parity;

  modport master (output cfg_data, output cfg_valid, output cfg_parity, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_parity, output cfg_ready);
`else
  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
`endif
endinterface

// File: rtl/cbx_wl_decoder.sv
// Registered one-hot word-line decoder; drives all-zero when disabled,
// when the frame is in error, or when the row is outside the port width.
module cbx_wl_decoder #(
  parameter int unsigned WL_W = 72,
  parameter int unsigned RW   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   row,
  input  logic            en,
  input  logic            err,
  output logic [WL_W-1:0] wl
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl <= '0;
    end else begin
      for (int unsigned i = 0; i < WL_W; i++) begin
        wl[i] <= en && !err && (32'(row) == i);
      end
    end
  end

endmodule

// File: rtl/cbx_mem_bank_loader.sv
// Frame loader for the X connection-block bit-line/word-line bank: header + NW
// data words build a shadow row, then bl is driven and one wl pulsed with margins.
// Optional odd-parity checking: CBX_MEM_BANK_LOADER_PARITY_EN.
module cbx_mem_bank_loader
  import cb_cfg_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BL_W     = 72,
  parameter int unsigned WL_W     = 72,
  parameter int unsigned WL_PULSE = 2
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  cbx_mem_bank_loader_if.slave  cfg,
  output logic [BL_W-1:0]       bl,
  output logic [WL_W-1:0]       wl,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int unsigned NW = calc_nw(BL_W, DATA_W);
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned RW = row_width(WL_W);

  localparam logic [CW-1:0] W_LAST  = CW'(NW - 1);
  localparam logic [3:0]    P_LAST  = 4'(WL_PULSE - 1);
  localparam logic [RW:0]   ROW_LIM = (RW + 1)'(WL_W);

  cb_state_e         state, state_nxt;
  logic [CW-1:0]     wcnt, wcnt_nxt;
  logic [3:0]        pcnt, pcnt_nxt;
  logic [RW-1:0]     row, row_nxt, hdr_row;
  logic              err_nxt;
  logic [BL_W-1:0]   shadow, shadow_nxt, bl_nxt;
  logic              accept;
  logic              par_bad;

  always_comb begin
    hdr_row = RW'(cfg.cfg_data);
    accept  = cfg.cfg_valid && cfg.cfg_ready;
`ifdef CBX_MEM_BANK_LOADER_PARITY_EN
    par_bad = ~(^{cfg.cfg_data, cfg.cfg_parity});
`else
    par_bad = 1'b0;
`endif
  end

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    pcnt_nxt   = pcnt;
    row_nxt    = row;
    err_nxt    = cfg_err;
    shadow_nxt = shadow;
    bl_nxt     = bl;
    unique case (state)
      IDLE: begin
        if (accept) begin
          row_nxt   = hdr_row;
          err_nxt   = ({1'b0, hdr_row} >= ROW_LIM) || par_bad;
          wcnt_nxt  = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          for (int unsigned b = 0; b < BL_W; b++) begin
            if (b / DATA_W == 32'(wcnt)) shadow_nxt[b] = cfg.cfg_data[b % DATA_W];
          end
          if (par_bad) err_nxt = 1'b1;
          if (wcnt == W_LAST) begin
            // bl loads together with the final word so it is settled a full
            // cycle before the registered decoder raises wl.
            bl_nxt    = shadow_nxt;
            wcnt_nxt  = '0;
            state_nxt = SETUP;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      SETUP: begin
        pcnt_nxt  = '0;
        state_nxt = WRITE;
      end
      WRITE: begin
        if (pcnt == P_LAST) begin
          pcnt_nxt  = '0;
          state_nxt = HOLD;
        end else begin
          pcnt_nxt = pcnt + 1'b1;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      wcnt          <= '0;
      pcnt          <= '0;
      row           <= '0;
      cfg_err       <= 1'b0;
      shadow        <= '0;
      bl            <= '0;
      cfg.cfg_ready <= 1'b0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      wcnt          <= wcnt_nxt;
      pcnt          <= pcnt_nxt;
      row           <= row_nxt;
      cfg_err       <= err_nxt;
      shadow        <= shadow_nxt;
      bl            <= bl_nxt;
      cfg.cfg_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
      busy          <= (state_nxt != IDLE);
      cfg_done      <= (state_nxt == HOLD);
    end
  end

  cbx_wl_decoder #(
    .WL_W (WL_W),
    .RW   (RW)
  ) u_wl_decoder (
    .clk (prog_clk),
    .rst (pReset),
    .row (row),
    .en  (state_nxt == WRITE),
    .err (cfg_err),
    .wl  (wl)
  );

endmodule
